// File: rtl/led_serial_receiver.sv
// led_serial_receiver: LSB-first serial shift register with latch-to-output transfer,
// frame length checking and an active-low gated LED output. Rev 1.0
`default_nettype none

module led_serial_receiver #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CLOCK_5,
   input  logic             reset,
   input  logic             sdi,
   input  logic             sclk,
   input  logic             latch,
   input  logic             n_output_enable,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] led_out,
   output logic             frame_valid,
   output logic             frame_error,
   output logic [7:0]       bit_count
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SHIFTING = 2'd1;
   localparam logic [1:0] ST_OVERRUN  = 2'd2;
   localparam logic [7:0] FULL_COUNT  = 8'(WIDTH);

   logic [SYNC_STAGES-1:0] sdi_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] latch_sync;
   logic [SYNC_STAGES-1:0] noe_sync;
   logic                   sclk_prev;
   logic                   latch_prev;
   logic                   sdi_s;
   logic                   sclk_s;
   logic                   latch_s;
   logic                   noe_s;
   logic                   sclk_edge;
   logic                   latch_edge;
   logic [WIDTH-1:0]       shift_reg;
   logic [WIDTH-1:0]       shift_next;
   logic [7:0]             count_next;
   logic [1:0]             state;

   // sdi shares the sclk depth so the sampled bit is aligned with the detected edge
   always_ff @(posedge CLOCK_5) begin
      if (reset) begin
         sdi_sync   <= '0;
         sclk_sync  <= '0;
         latch_sync <= '0;
         noe_sync   <= '0;
         sclk_prev  <= 1'b0;
         latch_prev <= 1'b0;
      end else begin
         sdi_sync   <= {sdi_sync[SYNC_STAGES-2:0], sdi};
         sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch};
         noe_sync   <= {noe_sync[SYNC_STAGES-2:0], n_output_enable};
         sclk_prev  <= sclk_s;
         latch_prev <= latch_s;
      end
   end

   assign sdi_s      = sdi_sync[SYNC_STAGES-1];
   assign sclk_s     = sclk_sync[SYNC_STAGES-1];
   assign latch_s    = latch_sync[SYNC_STAGES-1];
   assign noe_s      = noe_sync[SYNC_STAGES-1];
   assign sclk_edge  = sclk_s & ~sclk_prev;
   assign latch_edge = latch_s & ~latch_prev;

   // Shift is resolved before the latch so a coincident edge is included in the frame
   always_comb begin
      shift_next = shift_reg;
      count_next = bit_count;
      if (sclk_edge) begin
         shift_next = {sdi_s, shift_reg[WIDTH-1:1]};
         if (bit_count != 8'hFF) begin
            count_next = bit_count + 8'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_5) begin
      if (reset) begin
         shift_reg   <= '0;
         data_out    <= '0;
         led_out     <= '0;
         bit_count   <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         state       <= ST_IDLE;
      end else begin
         shift_reg   <= shift_next;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         led_out     <= noe_s ? '0 : data_out;
         if (latch_edge) begin
            data_out    <= shift_next;
            bit_count   <= '0;
            state       <= ST_IDLE;
            frame_valid <= (count_next == FULL_COUNT);
            frame_error <= (count_next != FULL_COUNT);
         end else begin
            bit_count <= count_next;
            if (sclk_edge) begin
               case (state)
                  ST_IDLE:     state <= ST_SHIFTING;
                  ST_SHIFTING: if (count_next > FULL_COUNT) state <= ST_OVERRUN;
                  ST_OVERRUN:  state <= ST_OVERRUN;
                  default:     state <= ST_IDLE;
               endcase
            end
         end
      end
   end

endmodule

`default_nettype wire
